// File: rtl/knn_pkg.sv
// Shared types and sizing helpers for the KNN point streamer and its training RAM.
package knn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int KNN_WIDTH    = 4;
  localparam int KNN_TAG      = 2;
  localparam int KNN_MEM_SIZE = 1024;

  // Address width for a memory of the given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int KNN_ADDR_W = addr_w(KNN_MEM_SIZE);

  // One coordinate: class tag in the MSBs, magnitude below.
  typedef struct packed {
    logic [KNN_TAG-1:0]   tag;
    logic [KNN_WIDTH-1:0] coord;
  } point_t;

endpackage

// File: rtl/knn_point_ram.sv
// Single-port training-point RAM with synchronous read and write.
module knn_point_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 12,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  // Only the read register is reset so the streamed point reads as zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_o <= '0;
    else if (re_i) rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/knn_point_streamer.sv
// Host-side initiator: holds the training set, streams (query, point) pairs to the
// KNN accelerator over valid/ready, then returns the accelerator's class result.
module knn_point_streamer
  import knn_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int MEM_SIZE = 1024,
  parameter  int TAG      = 2,
  localparam int ADDR_W   = addr_w(MEM_SIZE),
  localparam int PW       = TAG + WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_v_i,
  input  logic [PW-1:0]     wr_x_i,
  input  logic [PW-1:0]     wr_y_i,
  output logic              wr_ready_o,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [PW-1:0]     query_x_i,
  input  logic [PW-1:0]     query_y_i,
  input  logic [1:0]        sel_cfg_i,
  input  logic [ADDR_W-1:0] k_cfg_i,
  output logic [PW-1:0]     x1_o,
  output logic [PW-1:0]     y1_o,
  output logic [PW-1:0]     x2_o,
  output logic [PW-1:0]     y2_o,
  output logic [1:0]        sel_o,
  output logic [ADDR_W-1:0] num_o,
  output logic [ADDR_W-1:0] K_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              done_i,
  input  logic [TAG-1:0]    class_i,
  output logic [TAG-1:0]    class_o,
  output logic              class_v_o,
  output logic              err_o,
  output logic              busy_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, idx_q, rd_addr, ram_addr;
  logic              fire, last_xfer, start_ok, start_bad, wr_fire, ram_re;
  logic [2*PW-1:0]   ram_rdata;

  assign fire      = (state_q == STREAM) && valid_o && ready_i;
  assign last_xfer = fire && (idx_q == num_o - ADDR_W'(1));
  assign start_ok  = (state_q == IDLE) && start_i && (count_q != '0) &&
                     (k_cfg_i != '0) && (k_cfg_i <= count_q);
  assign start_bad = (state_q == IDLE) && start_i && !start_ok;

  // Write port closes while a start is presented so the RAM port is free for the read of point 0.
  assign wr_ready_o = !rst_i && (state_q == IDLE) && !start_i &&
                      (count_q < ADDR_W'(MEM_SIZE - 1));
  assign wr_fire    = wr_v_i && wr_ready_o && !clear_i;

  // Prefetch the next point on a transfer so a held-high ready gives one transfer per cycle.
  assign rd_addr  = start_ok ? '0 : (fire ? idx_q + ADDR_W'(1) : idx_q);
  assign ram_re   = start_ok || ((state_q == STREAM) && !abort_i);
  assign ram_addr = wr_fire ? count_q : rd_addr;

  assign x2_o   = ram_rdata[2*PW-1:PW];
  assign y2_o   = ram_rdata[PW-1:0];
  assign busy_o = (state_q != IDLE);

  knn_point_ram #(
    .DEPTH (MEM_SIZE),
    .DW    (2*PW),
    .AW    (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_fire),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i ({wr_x_i, wr_y_i}),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_ok) state_d = STREAM;
      STREAM: begin
        if (abort_i)        state_d = IDLE;
        else if (last_xfer) state_d = WAIT_DONE;
      end
      WAIT_DONE: if (abort_i || done_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '0;
      idx_q     <= '0;
      x1_o      <= '0;
      y1_o      <= '0;
      sel_o     <= '0;
      num_o     <= '0;
      K_o       <= '0;
      valid_o   <= 1'b0;
      class_o   <= '0;
      class_v_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      err_o     <= start_bad;
      class_v_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            x1_o    <= query_x_i;
            y1_o    <= query_y_i;
            sel_o   <= sel_cfg_i;
            num_o   <= count_q;
            K_o     <= k_cfg_i;
            idx_q   <= '0;
            valid_o <= 1'b1;
          end else if (!start_i) begin
            if (clear_i)      count_q <= '0;
            else if (wr_fire) count_q <= count_q + ADDR_W'(1);
          end
        end
        STREAM: begin
          if (abort_i)        valid_o <= 1'b0;
          else if (last_xfer) valid_o <= 1'b0;
          else if (fire)      idx_q   <= idx_q + ADDR_W'(1);
        end
        WAIT_DONE: begin
          if (!abort_i && done_i) begin
            class_o   <= class_i;
            class_v_o <= 1'b1;
          end
        end
        default: valid_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_point_streamer.sv
// Directed bench for knn_point_streamer: load, stream, stall, result, reject, abort, fill, reset.
module tb_knn_point_streamer;
  import knn_pkg::*;

  localparam int MEM = 1024;
  localparam int AW  = 10;
  localparam int PW  = 6;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_v_i = 1'b0;
  logic [PW-1:0] wr_x_i = '0, wr_y_i = '0;
  logic          wr_ready_o;
  logic          clear_i = 1'b0, start_i = 1'b0, abort_i = 1'b0;
  logic [PW-1:0] query_x_i = '0, query_y_i = '0;
  logic [1:0]    sel_cfg_i = '0;
  logic [AW-1:0] k_cfg_i = '0;
  logic [PW-1:0] x1_o, y1_o, x2_o, y2_o;
  logic [1:0]    sel_o;
  logic [AW-1:0] num_o, K_o;
  logic          valid_o;
  logic          ready_i = 1'b0, done_i = 1'b0;
  logic [1:0]    class_i = '0, class_o;
  logic          class_v_o, err_o, busy_o;

  int n_vec = 0;
  int n_err = 0;

  knn_point_streamer #(.WIDTH(4), .MEM_SIZE(MEM), .TAG(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_v_i(wr_v_i), .wr_x_i(wr_x_i), .wr_y_i(wr_y_i),
    .wr_ready_o(wr_ready_o), .clear_i(clear_i), .start_i(start_i), .abort_i(abort_i),
    .query_x_i(query_x_i), .query_y_i(query_y_i), .sel_cfg_i(sel_cfg_i), .k_cfg_i(k_cfg_i),
    .x1_o(x1_o), .y1_o(y1_o), .x2_o(x2_o), .y2_o(y2_o), .sel_o(sel_o), .num_o(num_o),
    .K_o(K_o), .valid_o(valid_o), .ready_i(ready_i), .done_i(done_i), .class_i(class_i),
    .class_o(class_o), .class_v_o(class_v_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [PW-1:0] pt(input logic [1:0] tag, input logic [3:0] c);
    point_t p;
    p.tag   = tag;
    p.coord = c;
    return p;
  endfunction

  task automatic write_pt(input logic [PW-1:0] x, input logic [PW-1:0] y);
    wr_v_i = 1'b1; wr_x_i = x; wr_y_i = y;
    tick();
    wr_v_i = 1'b0;
  endtask

  task automatic load3();
    write_pt(pt(2'd0, 4'd1), pt(2'd0, 4'd1));
    write_pt(pt(2'd1, 4'd5), pt(2'd1, 4'd5));
    write_pt(pt(2'd2, 4'd2), pt(2'd2, 4'd2));
  endtask

  task automatic go(input logic [AW-1:0] k);
    start_i = 1'b1; k_cfg_i = k;
    tick();
    start_i = 1'b0;
  endtask

  task automatic clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic finish_run(input logic [1:0] cls);
    done_i = 1'b1; class_i = cls;
    tick();
    done_i = 1'b0;
  endtask

  logic [PW-1:0]   exp_x [3];
  logic            rp [6];
  logic [2*PW-1:0] prev;
  int              nx, acc;

  initial begin
    exp_x[0] = 6'h01; exp_x[1] = 6'h15; exp_x[2] = 6'h22;
    rp[0] = 1; rp[1] = 0; rp[2] = 0; rp[3] = 1; rp[4] = 0; rp[5] = 1;

    // reset state
    #2;
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_x2", x2_o, 0);
    #10 rst_i = 1'b0;
    tick();
    chk("post_rst_wr_ready", wr_ready_o, 1);
    chk("post_rst_err", err_o, 0);

    // basic stream, ready held high
    load3();
    query_x_i = 6'h03; query_y_i = 6'h04; sel_cfg_i = 2'd2; ready_i = 1'b1;
    go(2);
    chk("t1_num", num_o, 3);
    chk("t1_k", K_o, 2);
    chk("t1_sel", sel_o, 2);
    chk("t1_x1", x1_o, 6'h03);
    chk("t1_y1", y1_o, 6'h04);
    chk("t1_busy", busy_o, 1);
    chk("t1_v0", valid_o, 1);
    chk("t1_x2_0", x2_o, 6'h01);
    chk("t1_y2_0", y2_o, 6'h01);
    tick();
    chk("t1_v1", valid_o, 1);
    chk("t1_x2_1", x2_o, 6'h15);
    tick();
    chk("t1_v2", valid_o, 1);
    chk("t1_x2_2", x2_o, 6'h22);
    tick();
    chk("t1_v_drop", valid_o, 0);
    chk("t1_wait_busy", busy_o, 1);
    finish_run(2'b10);
    chk("t1_class", class_o, 2);
    chk("t1_class_v", class_v_o, 1);
    chk("t1_idle", busy_o, 0);
    tick();
    chk("t1_class_v_pulse", class_v_o, 0);
    chk("t1_class_hold", class_o, 2);

    // stalled stream: ready 1,0,0,1,0,1
    ready_i = 1'b0;
    go(2);
    nx = 0;
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      ready_i = rp[i];
      if (i > 0 && !rp[i-1]) begin
        chk($sformatf("t2_hold%0d", i), {x2_o, y2_o}, prev);
        chk($sformatf("t2_vhold%0d", i), valid_o, 1);
      end
      if (valid_o && ready_i) begin
        if (nx < 3) chk($sformatf("t2_xfer%0d", nx), x2_o, exp_x[nx]);
        nx++;
      end
      prev = {x2_o, y2_o};
      tick();
    end
    ready_i = 1'b0;
    chk("t2_nxfer", nx, 3);
    chk("t2_v_drop", valid_o, 0);
    finish_run(2'b01);
    chk("t2_class", class_o, 1);

    // rejected starts
    go(0);
    chk("e_k0_err", err_o, 1);
    chk("e_k0_busy", busy_o, 0);
    chk("e_k0_valid", valid_o, 0);
    tick();
    chk("e_k0_pulse", err_o, 0);
    go(4);
    chk("e_k4_err", err_o, 1);
    chk("e_k4_busy", busy_o, 0);
    tick();
    chk("e_k4_pulse", err_o, 0);
    clear();
    go(1);
    chk("e_cnt0_err", err_o, 1);
    chk("e_cnt0_valid", valid_o, 0);
    tick();
    chk("e_cnt0_pulse", err_o, 0);

    // abort after first transfer, then restart from point 0
    load3();
    ready_i = 1'b1;
    go(1);
    chk("a_x2_0", x2_o, 6'h01);
    tick();
    chk("a_x2_1", x2_o, 6'h15);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("a_valid", valid_o, 0);
    chk("a_busy", busy_o, 0);
    chk("a_class_v", class_v_o, 0);
    go(2);
    chk("a_re_num", num_o, 3);
    chk("a_re_x2_0", x2_o, 6'h01);
    tick();
    chk("a_re_x2_1", x2_o, 6'h15);
    tick();
    chk("a_re_x2_2", x2_o, 6'h22);
    tick();
    chk("a_re_drop", valid_o, 0);
    finish_run(2'b11);
    chk("a_class", class_o, 3);

    // fill to capacity
    clear();
    acc = 0;
    wr_v_i = 1'b1;
    for (int i = 0; i < MEM; i++) begin
      wr_x_i = PW'(i); wr_y_i = PW'(i);
      if (wr_ready_o) acc++;
      tick();
    end
    wr_v_i = 1'b0;
    chk("f_accepted", acc, MEM - 1);
    chk("f_full", wr_ready_o, 0);
    clear();
    chk("f_clear_ready", wr_ready_o, 1);
    go(1);
    chk("f_clear_err", err_o, 1);

    // asynchronous reset mid-stream
    load3();
    ready_i = 1'b0;
    query_x_i = 6'h2A; query_y_i = 6'h15;
    go(1);
    chk("r_pre_valid", valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("r_valid", valid_o, 0);
    chk("r_x1", x1_o, 0);
    chk("r_x2", x2_o, 0);
    chk("r_num", num_o, 0);
    chk("r_k", K_o, 0);
    chk("r_busy", busy_o, 0);
    chk("r_class", class_o, 0);
    chk("r_wr_ready", wr_ready_o, 0);
    #1 rst_i = 1'b0;
    #1;
    chk("r_rel_wr_ready", wr_ready_o, 1);
    tick();
    go(1);
    chk("r_count0_err", err_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
